// File: rtl/seg_scan_disp.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_disp
// Purpose  : Byte-to-BCD (double-dabble) converter driving a 4-digit
//            multiplexed active-low seven-segment display.
// Option   : SEG_LEAD_ZERO_BLANK_EN blanks leading zeros on hundreds/tens.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_disp #(
    parameter int CNT_SCAN = 50_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       data_vld,
    output logic       busy,
    output logic [3:0] led_bit,
    output logic [7:0] led_out
);

    localparam int         c_CNT_W   = $clog2(CNT_SCAN);
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [7:0]         r_bin;
    logic [11:0]        r_bcd;
    logic [2:0]         r_iter;
    logic               r_busy;
    logic [3:0]         r_hun;
    logic [3:0]         r_ten;
    logic [3:0]         r_uni;
    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_led_bit;
    logic [7:0]         r_led_out;

    logic [11:0]        w_bcd_adj;
    logic               w_hun_blank;
    logic               w_ten_blank;
    logic [7:0]         w_seg;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_S_IDLE;
            r_bin   <= 8'd0;
            r_bcd   <= 12'd0;
            r_iter  <= 3'd0;
            r_busy  <= 1'b0;
            r_hun   <= 4'd0;
            r_ten   <= 4'd0;
            r_uni   <= 4'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (data_vld) begin
                        r_bin   <= data_in;
                        r_bcd   <= 12'd0;
                        r_iter  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_S_SHIFT;
                    end
                end
                c_S_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
                    r_iter         <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    // All three digits move together so the scan never sees a mix
                    r_hun   <= r_bcd[11:8];
                    r_ten   <= r_bcd[7:4];
                    r_uni   <= r_bcd[3:0];
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == c_CNT_W'(CNT_SCAN - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_CNT_W'(1);
        end
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    assign w_hun_blank = (r_hun == 4'd0);
    assign w_ten_blank = (r_hun == 4'd0) && (r_ten == 4'd0);
`else
    assign w_hun_blank = 1'b0;
    assign w_ten_blank = 1'b0;
`endif

    always_comb begin
        w_seg = 8'hFF;
        case (r_idx)
            2'd0:    w_seg = seg_code(r_uni);
            2'd1:    w_seg = w_ten_blank ? 8'hFF : seg_code(r_ten);
            2'd2:    w_seg = w_hun_blank ? 8'hFF : seg_code(r_hun);
            default: w_seg = 8'hFF;
        endcase
    end

    // Select and segments registered together to avoid ghosting between digits
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_led_bit <= 4'b1111;
            r_led_out <= 8'hFF;
        end else begin
            r_led_bit <= ~(4'b0001 << r_idx);
            r_led_out <= w_seg;
        end
    end

    assign busy    = r_busy;
    assign led_bit = r_led_bit;
    assign led_out = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_disp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg_scan_disp
// Purpose  : Self-checking bench for seg_scan_disp (CNT_SCAN = 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_disp;

    localparam int c_CNT = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] data_in;
    logic       data_vld;
    logic       busy;
    logic [3:0] led_bit;
    logic [7:0] led_out;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 sys_clk = ~sys_clk;

    seg_scan_disp #(.CNT_SCAN(c_CNT)) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .busy     (busy),
        .led_bit  (led_bit),
        .led_out  (led_out)
    );

    logic [7:0] c_seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit pattern from the decimal value with plain arithmetic
    function automatic logic [7:0] model_seg(input int val, input int idx);
        int h, t, u;
        h = val / 100;
        t = (val / 10) % 10;
        u = val % 10;
        case (idx)
            0: return c_seg_tab[u];
            1: begin
`ifdef SEG_LEAD_ZERO_BLANK_EN
                if (h == 0 && t == 0) return 8'hFF;
`endif
                return c_seg_tab[t];
            end
            2: begin
`ifdef SEG_LEAD_ZERO_BLANK_EN
                if (h == 0) return 8'hFF;
`endif
                return c_seg_tab[h];
            end
            default: return 8'hFF;
        endcase
    endfunction

    // Reference: edge count since reset drives the scan; a countdown models conversion
    int         m_k, m_left, m_pend, m_disp, m_idx;
    logic [3:0] m_bit;
    logic [7:0] m_out;
    logic       m_busy;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_k    = 0;
            m_left = 0;
            m_pend = 0;
            m_disp = 0;
            m_bit  = 4'hF;
            m_out  = 8'hFF;
            m_busy = 1'b0;
        end else begin
            m_k++;
            m_idx = ((m_k - 1) / c_CNT) % 4;
            m_bit = ~(4'b0001 << m_idx);
            m_out = model_seg(m_disp, m_idx);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end else if (data_vld) begin
                m_pend = int'(data_in);
                m_left = 9;
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("mon_busy",    {31'd0, busy},    {31'd0, m_busy});
            chk("mon_led_bit", {28'd0, led_bit}, {28'd0, m_bit});
            chk("mon_led_out", {24'd0, led_out}, {24'd0, m_out});
        end
    end

    typedef struct {
        logic [7:0] val;
        logic [7:0] u, t, h, t_lz, h_lz;
    } vec_t;
    vec_t       tab [8];
    logic [7:0] seen [4];

    task automatic send(input logic [7:0] v);
        @(negedge sys_clk);
        data_in  = v;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 30) chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic capture();
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        repeat (2) @(negedge sys_clk);
        for (int c = 0; c < 4 * c_CNT + 2; c++) begin
            @(negedge sys_clk);
            case (led_bit)
                4'b1110: seen[0] = led_out;
                4'b1101: seen[1] = led_out;
                4'b1011: seen[2] = led_out;
                4'b0111: seen[3] = led_out;
                default: ;
            endcase
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] u, input logic [7:0] t,
                             input logic [7:0] h);
        capture();
        chk({tag, "_units"},    {24'd0, seen[0]}, {24'd0, u});
        chk({tag, "_tens"},     {24'd0, seen[1]}, {24'd0, t});
        chk({tag, "_hundreds"}, {24'd0, seen[2]}, {24'd0, h});
        chk({tag, "_digit3"},   {24'd0, seen[3]}, 32'hFF);
    endtask

    initial begin
        int cnt, rises;
        logic prev;

        tab[0] = '{8'd255, 8'h92, 8'h92, 8'hA4, 8'h92, 8'hA4};
        tab[1] = '{8'd7,   8'hF8, 8'hC0, 8'hC0, 8'hFF, 8'hFF};
        tab[2] = '{8'd123, 8'hB0, 8'hA4, 8'hF9, 8'hA4, 8'hF9};
        tab[3] = '{8'd0,   8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF};
        tab[4] = '{8'd100, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hF9};
        tab[5] = '{8'd90,  8'hC0, 8'h90, 8'hC0, 8'h90, 8'hFF};
        tab[6] = '{8'd48,  8'h80, 8'h99, 8'hC0, 8'h99, 8'hFF};
        tab[7] = '{8'd206, 8'h82, 8'hC0, 8'hA4, 8'hC0, 8'hA4};

        sys_rst  = 1'b0;
        data_vld = 1'b0;
        data_in  = 8'd0;
        #1 sys_rst = 1'b1;
        #2;
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_led_bit", {28'd0, led_bit}, 32'hF);
        chk("rst_led_out", {24'd0, led_out}, 32'hFF);
        chk_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("first_led_bit", {28'd0, led_bit}, 32'hE);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        chk_frame("after_rst", 8'hC0, 8'hFF, 8'hFF);
`else
        chk_frame("after_rst", 8'hC0, 8'hC0, 8'hC0);
`endif

        // Full-scale value: busy width
        @(negedge sys_clk);
        data_in  = 8'd255;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
        cnt = 0;
        repeat (20) begin
            if (busy) cnt++;
            @(negedge sys_clk);
        end
        chk("busy_width", cnt, 32'd9);

        for (int i = 0; i < 8; i++) begin
            send(tab[i].val);
            wait_idle();
`ifdef SEG_LEAD_ZERO_BLANK_EN
            chk_frame($sformatf("tab%0d", i), tab[i].u, tab[i].t_lz, tab[i].h_lz);
`else
            chk_frame($sformatf("tab%0d", i), tab[i].u, tab[i].t, tab[i].h);
`endif
        end

        // Strobe while busy is dropped
        send(8'd123);
        repeat (2) @(negedge sys_clk);
        data_in  = 8'd45;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
        rises = 0;
        prev  = busy;
        repeat (30) begin
            @(negedge sys_clk);
            if (busy && !prev) rises++;
            prev = busy;
        end
        chk("drop_extra_busy", rises, 32'd0);
        chk_frame("drop", 8'hB0, 8'hA4, 8'hF9);

        // Reset in SHIFT iteration 4
        send(8'd200);
        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("midrst_busy",    {31'd0, busy},    32'd0);
        chk("midrst_led_bit", {28'd0, led_bit}, 32'hF);
        chk("midrst_led_out", {24'd0, led_out}, 32'hFF);
        @(negedge sys_clk);
        sys_rst = 1'b0;
`ifdef SEG_LEAD_ZERO_BLANK_EN
        chk_frame("midrst", 8'hC0, 8'hFF, 8'hFF);
`else
        chk_frame("midrst", 8'hC0, 8'hC0, 8'hC0);
`endif

        // Random strobes against the reference model
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            data_vld = ($urandom_range(0, 3) == 0);
            data_in  = 8'($urandom);
        end
        @(negedge sys_clk);
        data_vld = 1'b0;
        repeat (50) @(negedge sys_clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
